alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Sits directly downstream of the running-clock stage and beside the keyboard time-entry stage.
- Consumes the live time (hour/minute/second) and the keyboard-entered alarm time, and latches the alarm setting.
- Detects the alarm instant and drives a ring/buzzer output with stop, snooze and auto-timeout.
- Exports the latched alarm time for the HEX display path.

Parameters:
- RING_SECONDS, 60, number of 1 s ticks a ring lasts before auto-stop (1..255).
- SNOOZE_SECONDS, 300, number of 1 s ticks spent in snooze before re-ringing (1..1023).
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3).
- BEEP_DIV, 25000, number of CLK_50 cycles per buzzer half-period (1 kHz at 50 MHz).

Ports:
- CLK_50  in  1  system clock, 50 MHz
- reset_en  in  1  asynchronous active-low reset
- sec_clk  in  1  1 Hz square wave from the frequency divider; asynchronous to the logic below
- clock_hour  in  6  live hour, 0..23
- clock_minute  in  6  live minute, 0..59
- clock_second  in  6  live second, 0..59
- set_alarm_en  in  1  alarm-set mode switch
- alarm_hour_in  in  6  keyboard-entered hour
- alarm_minute_in  in  6  keyboard-entered minute
- alarm_second_in  in  6  keyboard-entered second
- entry_done  in  1  keyboard "entry complete" level; its rising edge is the load strobe
- alarm_on  in  1  arm switch, level
- stop_n  in  1  stop push-button, active-low, asynchronous
- snooze_n  in  1  snooze push-button, active-low, asynchronous
- alarm_hour  out  6  latched alarm hour
- alarm_minute  out  6  latched alarm minute
- alarm_second  out  6  latched alarm second
- alarm_armed  out  1  high in ARMED, RINGING or SNOOZE
- alarm_ring  out  1  high in RINGING
- buzzer  out  1  square wave while RINGING, else 0
- snooze_left  out  2  snoozes remaining

Behaviour:
- Input conditioning
  - sec_clk, stop_n, snooze_n and entry_done each pass through a 2-FF synchronizer plus an edge detector.
  - This produces 1-cycle pulses: tick (sec_clk rising), stop_p (stop_n falling), snz_p (snooze_n falling), load_p (entry_done rising).
  - Latency from the pin edge to the pulse is 3 CLK_50 cycles.
- Alarm latch
  - When set_alarm_en=1 and load_p: register alarm_in_* into alarm_*.
  - Out-of-range values (hour>23, min/sec>59) are rejected; the old value is kept.
  - The latch never updates while set_alarm_en=0.
- Match detection
  - match = (clock_* == alarm_*), registered each cycle as match_d.
  - trig = match & ~match_d, so the alarm fires once per entry into the matching second.
  - Match is suppressed while set_alarm_en=1.
- FSM states: IDLE, ARMED, RINGING, SNOOZE.
- Priority per cycle: reset > (alarm_on=0) > stop_p > snz_p > counter expiry > trig.
- Transitions:
  - any state with alarm_on=0 → IDLE on the next edge.
  - IDLE → ARMED when alarm_on=1.
  - ARMED → RINGING on trig; ring_cnt=0; snooze_left=MAX_SNOOZE.
  - RINGING → ARMED on stop_p.
  - RINGING → SNOOZE on snz_p when snooze_left>0; decrement snooze_left; snz_cnt=0.
  - snz_p with snooze_left=0 is ignored; ringing continues.
  - RINGING: ring_cnt increments on tick. At ring_cnt==RING_SECONDS-1 with tick → ARMED (auto-stop).
  - SNOOZE: snz_cnt increments on tick. At snz_cnt==SNOOZE_SECONDS-1 with tick → RINGING; ring_cnt cleared.
  - SNOOZE → ARMED on stop_p (cancels the remaining snoozes).
  - trig in RINGING or SNOOZE is ignored.
- Buzzer
  - beep_cnt counts 0..BEEP_DIV-1 and toggles buzzer on wrap, only in RINGING.
  - On leaving RINGING: buzzer=0 and beep_cnt=0 on the same edge the state changes.
- Reset values (asynchronous, while reset_en=0):
  - state=IDLE; alarm_*=0; all counters=0; snooze_left=0.
  - buzzer=0, alarm_ring=0, alarm_armed=0.
  - Synchronizer flops reset to the inactive level: sec_clk=0, stop_n=1, snooze_n=1, entry_done=0.
- Mid-operation
  - Reset during RINGING stops the buzzer immediately; there is no resume after release.
  - A changed alarm time while ARMED takes effect for the next match only.
- Live time jumping onto the alarm value (time set) counts as a trig if the FSM is ARMED.

Test Plan (RING_SECONDS=5, SNOOZE_SECONDS=3, MAX_SNOOZE=1, BEEP_DIV=4):
- Reset held, all inputs toggling → every output 0. Release with alarm_on=1 → alarm_armed=1 two cycles later.
- set_alarm_en=1, alarm_in=07:30:00, entry_done pulse → alarm_*=07:30:00. Repeat with hour=25 → value unchanged.
- Live time steps 07:29:59 → 07:30:00 → alarm_ring=1 the next cycle; buzzer period 8 CLK_50 cycles; after 5 ticks alarm_ring=0 and state ARMED.
- Ringing, snooze_n press → alarm_ring=0, snooze_left=0; after 3 ticks alarm_ring=1 again; second snooze press ignored; stop_n press → ARMED, buzzer=0.
- Ringing while time is held at 07:30:00, stop pressed → no re-trigger. Time leaves and returns to 07:30:00 → rings again.
- alarm_on dropped during SNOOZE → IDLE next cycle; a later match produces no ring. Simultaneous stop_p and snz_p in RINGING → ARMED (stop wins).

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller: latches the keyboard alarm time, detects the alarm instant and runs ring/snooze/buzzer control.
// Rev 1.0
`default_nettype none

module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int BEEP_DIV       = 25000
) (
  input  logic       CLK_50,
  input  logic       reset_en,
  input  logic       sec_clk,
  input  logic [5:0] clock_hour,
  input  logic [5:0] clock_minute,
  input  logic [5:0] clock_second,
  input  logic       set_alarm_en,
  input  logic [5:0] alarm_hour_in,
  input  logic [5:0] alarm_minute_in,
  input  logic [5:0] alarm_second_in,
  input  logic       entry_done,
  input  logic       alarm_on,
  input  logic       stop_n,
  input  logic       snooze_n,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_minute,
  output logic [5:0] alarm_second,
  output logic       alarm_armed,
  output logic       alarm_ring,
  output logic       buzzer,
  output logic [1:0] snooze_left
);

  localparam int              c_BW        = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam logic [7:0]      c_RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [9:0]      c_SNZ_LAST  = 10'(SNOOZE_SECONDS - 1);
  localparam logic [1:0]      c_MAX_SNZ   = 2'(MAX_SNOOZE);
  localparam logic [c_BW-1:0] c_BEEP_LAST = c_BW'(BEEP_DIV - 1);
  // Idle levels of {entry_done, snooze_n, stop_n, sec_clk}
  localparam logic [3:0]      c_SYNC_RST  = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  logic [3:0]      w_pins;
  logic [3:0]      r_sync1, r_sync2, r_sync3;
  logic            r_tick, r_stop_p, r_snz_p, r_load_p;
  logic            w_in_valid, w_match, w_trig, r_match_d;
  state_t          r_state;
  logic [7:0]      r_ring_cnt;
  logic [9:0]      r_snz_cnt;
  logic [c_BW-1:0] r_beep_cnt;

  assign w_pins = {entry_done, snooze_n, stop_n, sec_clk};

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      r_sync1  <= c_SYNC_RST;
      r_sync2  <= c_SYNC_RST;
      r_sync3  <= c_SYNC_RST;
      r_tick   <= 1'b0;
      r_stop_p <= 1'b0;
      r_snz_p  <= 1'b0;
      r_load_p <= 1'b0;
    end else begin
      r_sync1  <= w_pins;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_tick   <=  r_sync2[0] & ~r_sync3[0];
      r_stop_p <= ~r_sync2[1] &  r_sync3[1];
      r_snz_p  <= ~r_sync2[2] &  r_sync3[2];
      r_load_p <=  r_sync2[3] & ~r_sync3[3];
    end
  end

  assign w_in_valid = (alarm_hour_in <= 6'd23) && (alarm_minute_in <= 6'd59) &&
                      (alarm_second_in <= 6'd59);

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      alarm_hour   <= 6'd0;
      alarm_minute <= 6'd0;
      alarm_second <= 6'd0;
    end else if (set_alarm_en && r_load_p && w_in_valid) begin
      alarm_hour   <= alarm_hour_in;
      alarm_minute <= alarm_minute_in;
      alarm_second <= alarm_second_in;
    end
  end

  // Fire only on entry into the matching second, never while the alarm is being edited
  assign w_match = ~set_alarm_en && (clock_hour == alarm_hour) &&
                   (clock_minute == alarm_minute) && (clock_second == alarm_second);
  assign w_trig  = w_match & ~r_match_d;

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) r_match_d <= 1'b0;
    else           r_match_d <= w_match;
  end

  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      r_state     <= S_IDLE;
      r_ring_cnt  <= '0;
      r_snz_cnt   <= '0;
      r_beep_cnt  <= '0;
      snooze_left <= '0;
      buzzer      <= 1'b0;
      alarm_ring  <= 1'b0;
      alarm_armed <= 1'b0;
    end else if (!alarm_on) begin
      r_state     <= S_IDLE;
      alarm_armed <= 1'b0;
      alarm_ring  <= 1'b0;
      buzzer      <= 1'b0;
      r_beep_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_ARMED;
          alarm_armed <= 1'b1;
        end
        S_ARMED: begin
          if (w_trig) begin
            r_state     <= S_RINGING;
            alarm_ring  <= 1'b1;
            r_ring_cnt  <= '0;
            snooze_left <= c_MAX_SNZ;
          end
        end
        S_RINGING: begin
          if (r_stop_p) begin
            r_state    <= S_ARMED;
            alarm_ring <= 1'b0;
            buzzer     <= 1'b0;
            r_beep_cnt <= '0;
          end else if (r_snz_p && snooze_left != 2'd0) begin
            r_state     <= S_SNOOZE;
            snooze_left <= snooze_left - 2'd1;
            r_snz_cnt   <= '0;
            alarm_ring  <= 1'b0;
            buzzer      <= 1'b0;
            r_beep_cnt  <= '0;
          end else if (r_tick && r_ring_cnt == c_RING_LAST) begin
            r_state    <= S_ARMED;
            alarm_ring <= 1'b0;
            buzzer     <= 1'b0;
            r_beep_cnt <= '0;
          end else begin
            if (r_tick) r_ring_cnt <= r_ring_cnt + 8'd1;
            if (r_beep_cnt == c_BEEP_LAST) begin
              r_beep_cnt <= '0;
              buzzer     <= ~buzzer;
            end else begin
              r_beep_cnt <= r_beep_cnt + c_BW'(1);
            end
          end
        end
        S_SNOOZE: begin
          if (r_stop_p) begin
            r_state     <= S_ARMED;
            snooze_left <= '0;
          end else if (r_tick) begin
            if (r_snz_cnt == c_SNZ_LAST) begin
              r_state    <= S_RINGING;
              alarm_ring <= 1'b1;
              r_ring_cnt <= '0;
            end else begin
              r_snz_cnt <= r_snz_cnt + 10'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed + randomized checks of alarm_controller against arithmetic expectations.
`default_nettype none

module tb_alarm_controller;

  localparam int RING = 5;
  localparam int SNZ  = 3;
  localparam int MAXS = 1;
  localparam int BDIV = 4;

  logic       CLK_50 = 1'b0;
  logic       reset_en = 1'b0;
  logic       sec_clk = 1'b0;
  logic [5:0] clock_hour = 6'd63, clock_minute = 6'd63, clock_second = 6'd63;
  logic       set_alarm_en = 1'b0;
  logic [5:0] alarm_hour_in = 6'd0, alarm_minute_in = 6'd0, alarm_second_in = 6'd0;
  logic       entry_done = 1'b0;
  logic       alarm_on = 1'b0;
  logic       stop_n = 1'b1;
  logic       snooze_n = 1'b1;
  logic [5:0] alarm_hour, alarm_minute, alarm_second;
  logic       alarm_armed, alarm_ring, buzzer;
  logic [1:0] snooze_left;

  int checks = 0;
  int errors = 0;
  int exp_h = 0, exp_m = 0, exp_s = 0;
  int exp_left = 0;

  alarm_controller #(
    .RING_SECONDS(RING), .SNOOZE_SECONDS(SNZ), .MAX_SNOOZE(MAXS), .BEEP_DIV(BDIV)
  ) dut (
    .CLK_50(CLK_50), .reset_en(reset_en), .sec_clk(sec_clk),
    .clock_hour(clock_hour), .clock_minute(clock_minute), .clock_second(clock_second),
    .set_alarm_en(set_alarm_en),
    .alarm_hour_in(alarm_hour_in), .alarm_minute_in(alarm_minute_in),
    .alarm_second_in(alarm_second_in),
    .entry_done(entry_done), .alarm_on(alarm_on), .stop_n(stop_n), .snooze_n(snooze_n),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_second(alarm_second),
    .alarm_armed(alarm_armed), .alarm_ring(alarm_ring), .buzzer(buzzer),
    .snooze_left(snooze_left)
  );

  always #5 CLK_50 = ~CLK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    clock_hour   = 6'(h);
    clock_minute = 6'(m);
    clock_second = 6'(s);
  endtask

  // Entry strobe reaches the latch 4 edges after the pin rises
  task automatic load_alarm(input int h, input int m, input int s);
    alarm_hour_in   = 6'(h);
    alarm_minute_in = 6'(m);
    alarm_second_in = 6'(s);
    entry_done = 1'b1;
    step(4);
    entry_done = 1'b0;
    step(3);
    if (set_alarm_en && h <= 23 && m <= 59 && s <= 59) begin
      exp_h = h; exp_m = m; exp_s = s;
    end
  endtask

  task automatic check_latch(input string tag);
    check({tag, "_hour"},   32'(alarm_hour),   32'(exp_h));
    check({tag, "_minute"}, 32'(alarm_minute), 32'(exp_m));
    check({tag, "_second"}, 32'(alarm_second), 32'(exp_s));
  endtask

  task automatic press(input bit do_stop, input bit do_snz);
    if (do_stop) stop_n = 1'b0;
    if (do_snz)  snooze_n = 1'b0;
    step(4);
    stop_n = 1'b1;
    snooze_n = 1'b1;
    step(3);
  endtask

  task automatic do_tick();
    sec_clk = 1'b1;
    step(4);
    sec_clk = 1'b0;
    step(3);
  endtask

  task automatic trigger();
    set_time(7, 29, 59);
    step(1);
    set_time(7, 30, 0);
    step(1);
    exp_left = MAXS;
  endtask

  initial begin
    // Reset held with inputs thrashing: every output must stay at zero
    for (int i = 0; i < 12; i++) begin
      sec_clk = 1'($urandom); stop_n = 1'($urandom); snooze_n = 1'($urandom);
      entry_done = 1'($urandom); alarm_on = 1'($urandom); set_alarm_en = 1'($urandom);
      alarm_hour_in = 6'($urandom); alarm_minute_in = 6'($urandom);
      alarm_second_in = 6'($urandom);
      set_time($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      step(1);
      check("reset_outputs", 32'({alarm_hour, alarm_minute, alarm_second, alarm_armed,
                                  alarm_ring, buzzer, snooze_left}), 32'd0);
    end
    sec_clk = 1'b0; stop_n = 1'b1; snooze_n = 1'b1; entry_done = 1'b0;
    set_alarm_en = 1'b0; alarm_on = 1'b1;
    set_time(63, 63, 63);
    reset_en = 1'b1;
    step(2);
    check("armed_after_release", 32'(alarm_armed), 32'd1);
    check("no_ring_after_release", 32'(alarm_ring), 32'd0);

    // Alarm latch: valid load, out-of-range rejects, no update while not in set mode
    set_alarm_en = 1'b1;
    load_alarm(7, 30, 0);
    check_latch("load_0730");
    load_alarm(25, 30, 0);
    check_latch("reject_hour25");
    load_alarm(7, 60, 0);
    check_latch("reject_min60");
    set_alarm_en = 1'b0;
    load_alarm(8, 0, 0);
    check_latch("no_load_unset");
    for (int i = 0; i < 6; i++) begin
      set_alarm_en = 1'($urandom_range(0, 1));
      load_alarm($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      check_latch("rand_load");
    end
    set_alarm_en = 1'b1;
    load_alarm(7, 30, 0);
    set_alarm_en = 1'b0;
    step(1);
    check_latch("reload_0730");

    // Ring on match, buzzer square wave, auto-stop after RING ticks
    trigger();
    check("ring_on_match", 32'(alarm_ring), 32'd1);
    check("snooze_left_loaded", 32'(snooze_left), 32'(exp_left));
    check("buzzer_start", 32'(buzzer), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("buzzer_wave", 32'(buzzer), 32'((k / BDIV) % 2));
    end
    for (int t = 1; t <= RING; t++) begin
      do_tick();
      check("ring_timeout", 32'(alarm_ring), 32'(t < RING));
    end
    check("armed_after_timeout", 32'(alarm_armed), 32'd1);
    check("buzzer_off_timeout", 32'(buzzer), 32'd0);

    // Snooze, re-ring after SNZ ticks, exhausted snooze ignored, stop
    trigger();
    check("ring_before_snooze", 32'(alarm_ring), 32'd1);
    press(1'b0, 1'b1);
    exp_left = exp_left - 1;
    check("snooze_ring_off", 32'(alarm_ring), 32'd0);
    check("snooze_left_dec", 32'(snooze_left), 32'(exp_left));
    check("snooze_armed", 32'(alarm_armed), 32'd1);
    for (int t = 1; t <= SNZ; t++) begin
      do_tick();
      check("snooze_rering", 32'(alarm_ring), 32'(t >= SNZ));
    end
    press(1'b0, 1'b1);
    check("snooze_exhausted_ring", 32'(alarm_ring), 32'd1);
    check("snooze_exhausted_left", 32'(snooze_left), 32'd0);
    press(1'b1, 1'b0);
    check("stop_ring_off", 32'(alarm_ring), 32'd0);
    check("stop_armed", 32'(alarm_armed), 32'd1);
    check("stop_buzzer_off", 32'(buzzer), 32'd0);

    // Stop while time is held on the alarm second: no re-trigger until time leaves and returns
    trigger();
    press(1'b1, 1'b0);
    step(10);
    check("no_retrigger_held", 32'(alarm_ring), 32'd0);
    set_time(7, 30, 1);
    step(1);
    set_time(7, 30, 0);
    step(1);
    exp_left = MAXS;
    check("retrigger_on_return", 32'(alarm_ring), 32'd1);

    // alarm_on dropped during snooze goes idle; later match is ignored
    press(1'b0, 1'b1);
    check("snooze_state_armed", 32'(alarm_armed), 32'd1);
    check("snooze_state_ring", 32'(alarm_ring), 32'd0);
    alarm_on = 1'b0;
    step(1);
    check("off_idle", 32'(alarm_armed), 32'd0);
    trigger();
    check("off_no_ring", 32'(alarm_ring), 32'd0);
    alarm_on = 1'b1;
    step(1);
    check("rearm", 32'(alarm_armed), 32'd1);
    check("rearm_no_ring", 32'(alarm_ring), 32'd0);

    // Simultaneous stop and snooze: stop wins, snooze count untouched
    trigger();
    check("ring_before_both", 32'(alarm_ring), 32'd1);
    press(1'b1, 1'b1);
    check("both_ring_off", 32'(alarm_ring), 32'd0);
    check("both_armed", 32'(alarm_armed), 32'd1);
    check("both_left_kept", 32'(snooze_left), 32'(exp_left));

    // Time jump onto the alarm value, then reset mid-ring
    set_time(12, 0, 0);
    step(1);
    set_time(7, 30, 0);
    step(1);
    check("jump_trig", 32'(alarm_ring), 32'd1);
    step(5);
    check("buzzer_before_reset", 32'(buzzer), 32'((6 / BDIV) % 2));
    #2;
    reset_en = 1'b0;
    #1;
    check("async_reset_ring", 32'(alarm_ring), 32'd0);
    check("async_reset_buzzer", 32'(buzzer), 32'd0);
    step(1);
    reset_en = 1'b1;
    exp_h = 0; exp_m = 0; exp_s = 0;
    step(2);
    check("post_reset_armed", 32'(alarm_armed), 32'd1);
    check("post_reset_no_resume", 32'(alarm_ring), 32'd0);
    check_latch("post_reset_latch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
